// File: rtl/scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// scoreboard_pkg
// Shared definitions for the control scoreboard: default register-file sizes,
// the matching index widths, and the halt/drain state encoding.
// -----------------------------------------------------------------------------
package scoreboard_pkg;

    localparam int NUM_SREGS_DEF = 32;
    localparam int NUM_VREGS_DEF = 32;
    localparam int SREG_W        = $clog2(NUM_SREGS_DEF);
    localparam int VREG_W        = $clog2(NUM_VREGS_DEF);

    typedef enum logic [1:0] {
        SB_RUN,
        SB_DRAIN,
        SB_HALTED
    } sb_state_t;

endpackage

// File: rtl/sb_counter_bank.sv
// -----------------------------------------------------------------------------
// sb_counter_bank
// One outstanding-write counter per architectural register. Issue increments,
// writeback decrements, and both on the same register in one cycle cancel.
// A writeback to a zero counter leaves it at zero and raises `underflow`.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   inc_en, inc_idx     accepted issue writing register inc_idx
//   dec_en, dec_idx     writeback retiring register dec_idx
//   rd1_idx, rd2_idx    source indices for the RAW queries
//   rd1_busy, rd2_busy  source has an outstanding write
//   full_idx, full      destination counter is saturated
//   nonzero             any counter nonzero
//   underflow           writeback this cycle targets a zero counter
//
// Build option SCOREBOARD_BYPASS_EN: a source whose counter is exactly 1 and
// whose writeback retires this same cycle is not reported busy (the register
// file forwards the write-through value).
// -----------------------------------------------------------------------------
module sb_counter_bank #(
    parameter  int NREGS = 32,
    parameter  int CNT_W = 2,
    localparam int IDX_W = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    input  logic [IDX_W-1:0] inc_idx,
    input  logic             dec_en,
    input  logic [IDX_W-1:0] dec_idx,
    input  logic [IDX_W-1:0] rd1_idx,
    input  logic [IDX_W-1:0] rd2_idx,
    input  logic [IDX_W-1:0] full_idx,
    output logic             rd1_busy,
    output logic             rd2_busy,
    output logic             full,
    output logic             nonzero,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt [NREGS];
    logic [NREGS-1:0] inc_hit;
    logic [NREGS-1:0] dec_hit;

    // NOTE: every variable driven from always_comb gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        nonzero = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            inc_hit[i] = inc_en && (inc_idx == IDX_W'(i));
            dec_hit[i] = dec_en && (dec_idx == IDX_W'(i));
            nonzero    = nonzero | (cnt[i] != '0);
        end
    end

    // NOTE: the counter array is reset explicitly -- it is live control state
    // (a stale count would stall issue forever), not a data RAM.
    // NOTE: state is updated with non-blocking assignments so all counters see
    // the same pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (inc_hit[i] && !dec_hit[i])
                    cnt[i] <= cnt[i] + CNT_ONE;
                else if (dec_hit[i] && !inc_hit[i] && cnt[i] != '0)
                    cnt[i] <= cnt[i] - CNT_ONE;
            end
        end
    end

    assign underflow = dec_en && (cnt[dec_idx] == '0);
    assign full      = (cnt[full_idx] == CNT_MAX);

`ifdef SCOREBOARD_BYPASS_EN
    // The last outstanding write retiring this cycle is visible through the
    // register file's write-through path, so it no longer blocks the reader.
    assign rd1_busy = (cnt[rd1_idx] != '0) &&
                      !(dec_en && (dec_idx == rd1_idx) && (cnt[rd1_idx] == CNT_ONE));
    assign rd2_busy = (cnt[rd2_idx] != '0) &&
                      !(dec_en && (dec_idx == rd2_idx) && (cnt[rd2_idx] == CNT_ONE));
`else
    assign rd1_busy = (cnt[rd1_idx] != '0);
    assign rd2_busy = (cnt[rd2_idx] != '0);
`endif

endmodule

// File: rtl/control_scoreboard.sv
// -----------------------------------------------------------------------------
// control_scoreboard
// Issue-stage scoreboard beside the decode-to-execute control register.
// Tracks outstanding scalar and vector destination writes, stalls issue on RAW
// hazards, on a saturated destination counter (WAW overflow) and while
// draining/halted, and reports when a halt has fully drained.
//
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   issue_valid, issue_flush          instruction present / squashed at issue
//   r_read1/2, scalar_read_register1/2  scalar sources
//   v_read1/2, vector_read_register1/2  vector sources
//   register_wr_en, scalar_write_register  scalar destination
//   vector_wr_en, vector_write_register    vector destination
//   halt                              instruction at issue is a halt
//   wb_scalar_valid/_reg, wb_vector_valid/_reg  retiring writebacks
//   issue_stall   hold decode; control register must not capture (comb)
//   issue_accept  instruction issued this cycle (comb)
//   pending_any   any outstanding write counter nonzero
//   halted        halt has drained (registered)
//   underflow_err sticky writeback-to-zero-counter flag (registered)
//
// Build option SCOREBOARD_BYPASS_EN: same-cycle writeback of the last
// outstanding write to a source clears that RAW hazard.
// -----------------------------------------------------------------------------
module control_scoreboard
    import scoreboard_pkg::*;
#(
    parameter  int NUM_SREGS = NUM_SREGS_DEF,
    parameter  int NUM_VREGS = NUM_VREGS_DEF,
    parameter  int CNT_W     = 2,
    localparam int S_W       = $clog2(NUM_SREGS),
    localparam int V_W       = $clog2(NUM_VREGS)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           issue_valid,
    input  logic           issue_flush,
    input  logic           r_read1,
    input  logic           r_read2,
    input  logic [S_W-1:0] scalar_read_register1,
    input  logic [S_W-1:0] scalar_read_register2,
    input  logic           v_read1,
    input  logic           v_read2,
    input  logic [V_W-1:0] vector_read_register1,
    input  logic [V_W-1:0] vector_read_register2,
    input  logic           register_wr_en,
    input  logic [S_W-1:0] scalar_write_register,
    input  logic           vector_wr_en,
    input  logic [V_W-1:0] vector_write_register,
    input  logic           halt,
    input  logic           wb_scalar_valid,
    input  logic [S_W-1:0] wb_scalar_reg,
    input  logic           wb_vector_valid,
    input  logic [V_W-1:0] wb_vector_reg,
    output logic           issue_stall,
    output logic           issue_accept,
    output logic           pending_any,
    output logic           halted,
    output logic           underflow_err
);

    sb_state_t state;

    logic s_rd1_busy, s_rd2_busy, s_full, s_nonzero, s_underflow;
    logic v_rd1_busy, v_rd2_busy, v_full, v_nonzero, v_underflow;
    logic issue_live, raw, waw_full;

    sb_counter_bank #(.NREGS(NUM_SREGS), .CNT_W(CNT_W)) u_sbank (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (issue_accept & register_wr_en),
        .inc_idx   (scalar_write_register),
        .dec_en    (wb_scalar_valid),
        .dec_idx   (wb_scalar_reg),
        .rd1_idx   (scalar_read_register1),
        .rd2_idx   (scalar_read_register2),
        .full_idx  (scalar_write_register),
        .rd1_busy  (s_rd1_busy),
        .rd2_busy  (s_rd2_busy),
        .full      (s_full),
        .nonzero   (s_nonzero),
        .underflow (s_underflow)
    );

    sb_counter_bank #(.NREGS(NUM_VREGS), .CNT_W(CNT_W)) u_vbank (
        .clk       (clk),
        .rst       (rst),
        .inc_en    (issue_accept & vector_wr_en),
        .inc_idx   (vector_write_register),
        .dec_en    (wb_vector_valid),
        .dec_idx   (wb_vector_reg),
        .rd1_idx   (vector_read_register1),
        .rd2_idx   (vector_read_register2),
        .full_idx  (vector_write_register),
        .rd1_busy  (v_rd1_busy),
        .rd2_busy  (v_rd2_busy),
        .full      (v_full),
        .nonzero   (v_nonzero),
        .underflow (v_underflow)
    );

    // A flushed instruction never stalls: it is dropped, so holding decode for
    // it would only cost a cycle.
    assign issue_live = issue_valid & ~issue_flush;

    assign raw = (r_read1 & s_rd1_busy) | (r_read2 & s_rd2_busy) |
                 (v_read1 & v_rd1_busy) | (v_read2 & v_rd2_busy);

    // WAW uses the registered count only; a same-cycle writeback frees the
    // slot for the following cycle.
    assign waw_full = (register_wr_en & s_full) | (vector_wr_en & v_full);

    assign issue_stall  = issue_live & (raw | waw_full | (state != SB_RUN));
    assign issue_accept = issue_live & ~issue_stall;
    assign pending_any  = s_nonzero | v_nonzero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= SB_RUN;
            halted        <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (s_underflow | v_underflow)
                underflow_err <= 1'b1;

            case (state)
                SB_RUN: begin
                    if (issue_accept && halt)
                        state <= SB_DRAIN;
                end
                SB_DRAIN: begin
                    // pending_any reflects the registered counters, so this
                    // fires the cycle after the last writeback has landed.
                    if (!pending_any) begin
                        state  <= SB_HALTED;
                        halted <= 1'b1;
                    end
                end
                SB_HALTED: begin
                    // Terminal until reset.
                end
                default: begin
                    state  <= SB_RUN;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_control_scoreboard
// Directed stimulus; each checked cycle pushes its hand-computed expected
// outputs {issue_stall, issue_accept, pending_any, halted, underflow_err}
// into a queue. A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_control_scoreboard;
    import scoreboard_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic issue_valid, issue_flush;
    logic r_read1, r_read2, v_read1, v_read2;
    logic [SREG_W-1:0] scalar_read_register1, scalar_read_register2;
    logic [VREG_W-1:0] vector_read_register1, vector_read_register2;
    logic register_wr_en, vector_wr_en, halt;
    logic [SREG_W-1:0] scalar_write_register;
    logic [VREG_W-1:0] vector_write_register;
    logic wb_scalar_valid, wb_vector_valid;
    logic [SREG_W-1:0] wb_scalar_reg;
    logic [VREG_W-1:0] wb_vector_reg;
    logic issue_stall, issue_accept, pending_any, halted, underflow_err;

    typedef struct {
        string      name;
        logic [4:0] exp;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    control_scoreboard dut (
        .clk                   (clk),
        .rst                   (rst),
        .issue_valid           (issue_valid),
        .issue_flush           (issue_flush),
        .r_read1               (r_read1),
        .r_read2               (r_read2),
        .scalar_read_register1 (scalar_read_register1),
        .scalar_read_register2 (scalar_read_register2),
        .v_read1               (v_read1),
        .v_read2               (v_read2),
        .vector_read_register1 (vector_read_register1),
        .vector_read_register2 (vector_read_register2),
        .register_wr_en        (register_wr_en),
        .scalar_write_register (scalar_write_register),
        .vector_wr_en          (vector_wr_en),
        .vector_write_register (vector_write_register),
        .halt                  (halt),
        .wb_scalar_valid       (wb_scalar_valid),
        .wb_scalar_reg         (wb_scalar_reg),
        .wb_vector_valid       (wb_vector_valid),
        .wb_vector_reg         (wb_vector_reg),
        .issue_stall           (issue_stall),
        .issue_accept          (issue_accept),
        .pending_any           (pending_any),
        .halted                (halted),
        .underflow_err         (underflow_err)
    );

    // Monitor: outputs are compared half a cycle after inputs settle.
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if ({issue_stall, issue_accept, pending_any, halted, underflow_err} !== mon_e.exp) begin
                errors++;
                $display("FAIL %s: stall/accept/pending/halted/uerr got=%b want=%b",
                         mon_e.name,
                         {issue_stall, issue_accept, pending_any, halted, underflow_err},
                         mon_e.exp);
            end
        end
    end

    task automatic clear_inputs();
        issue_valid = 0; issue_flush = 0;
        r_read1 = 0; r_read2 = 0; v_read1 = 0; v_read2 = 0;
        scalar_read_register1 = '0; scalar_read_register2 = '0;
        vector_read_register1 = '0; vector_read_register2 = '0;
        register_wr_en = 0; scalar_write_register = '0;
        vector_wr_en = 0; vector_write_register = '0;
        halt = 0;
        wb_scalar_valid = 0; wb_scalar_reg = '0;
        wb_vector_valid = 0; wb_vector_reg = '0;
    endtask

    // Queue the expectation for the inputs currently applied, then advance.
    task automatic cycle(input string name, input logic [4:0] exp);
        exp_q.push_back('{name, exp});
        @(posedge clk); #1;
        clear_inputs();
    endtask

    task automatic reset_cycle();
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        clear_inputs();
    endtask

    task automatic sw(input logic [SREG_W-1:0] r);
        issue_valid = 1; register_wr_en = 1; scalar_write_register = r;
    endtask

    task automatic sr1(input logic [SREG_W-1:0] r);
        issue_valid = 1; r_read1 = 1; scalar_read_register1 = r;
    endtask

    task automatic vw(input logic [VREG_W-1:0] r);
        issue_valid = 1; vector_wr_en = 1; vector_write_register = r;
    endtask

    task automatic swb(input logic [SREG_W-1:0] r);
        wb_scalar_valid = 1; wb_scalar_reg = r;
    endtask

    task automatic vwb(input logic [VREG_W-1:0] r);
        wb_vector_valid = 1; wb_vector_reg = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        cycle("reset_idle", 5'b00000);

        // RAW on s5 resolved by writeback.
        sw(5);                cycle("s5_write",        5'b01000);
        sr1(5);               cycle("s5_raw_c2",       5'b10100);
        sr1(5);               cycle("s5_raw_c3",       5'b10100);
        sr1(5); swb(5);
`ifdef SCOREBOARD_BYPASS_EN
                              cycle("s5_raw_wb_c4",    5'b01100);
`else
                              cycle("s5_raw_wb_c4",    5'b10100);
`endif
        sr1(5);               cycle("s5_read_c5",      5'b01000);

        // WAW saturation on v3.
        vw(3);                cycle("v3_w1",           5'b01000);
        vw(3);                cycle("v3_w2",           5'b01100);
        vw(3);                cycle("v3_w3",           5'b01100);
        vw(3);                cycle("v3_w4_full",      5'b10100);
        vw(3); vwb(3);        cycle("v3_w4_full_wb",   5'b10100);
        vw(3);                cycle("v3_w4_accept",    5'b01100);
        vw(3);                cycle("v3_w5_full",      5'b10100);
        vwb(3);               cycle("v3_wb_a",         5'b00100);
        vwb(3);               cycle("v3_wb_b",         5'b00100);
        vwb(3);               cycle("v3_wb_c",         5'b00100);
                              cycle("v3_drained",      5'b00000);

        // Same-cycle inc and dec on s7 keeps count at 1.
        sw(7);                cycle("s7_write",        5'b01000);
        sw(7); swb(7);        cycle("s7_write_wb",     5'b01100);
                              cycle("s7_count1",       5'b00100);
        swb(7);               cycle("s7_wb",           5'b00100);
                              cycle("s7_drained",      5'b00000);

        // Flush drops the instruction without stall or increment.
        sw(4);                cycle("s4_write",        5'b01000);
        sw(4); sr1(4); issue_flush = 1;
                              cycle("s4_flush",        5'b00100);
        swb(4);               cycle("s4_wb",           5'b00100);
                              cycle("s4_unchanged",    5'b00000);

        // Halt drain with s2 outstanding.
        sw(2);                cycle("halt_s2_write",   5'b01000);
        issue_valid = 1; halt = 1;
                              cycle("halt_accept",     5'b01100);
        issue_valid = 1;      cycle("drain_stall_a",   5'b10100);
        issue_valid = 1; swb(2);
                              cycle("drain_stall_wb",  5'b10100);
        issue_valid = 1;      cycle("drain_zero",      5'b10000);
        issue_valid = 1;      cycle("halted_stall",    5'b10010);

        // Underflow: writeback to s9 with count 0.
        swb(9);               cycle("uflow_wb_s9",     5'b00010);
                              cycle("uflow_set",       5'b00011);
                              cycle("uflow_sticky",    5'b00011);
        reset_cycle();
                              cycle("post_reset",      5'b00000);

        // Reset mid-DRAIN discards state; stale writeback underflows.
        sw(2);                cycle("rd_s2_write",     5'b01000);
        sw(3); halt = 1;      cycle("rd_halt_w3",      5'b01100);
        issue_valid = 1;      cycle("rd_drain",        5'b10100);
        reset_cycle();
        sr1(2); register_wr_en = 1; scalar_write_register = 3;
                              cycle("rd_run_accept",   5'b01000);
        swb(2);               cycle("rd_stale_wb",     5'b00100);
                              cycle("rd_uflow",        5'b00101);
        swb(3);               cycle("rd_s3_wb",        5'b00101);
                              cycle("rd_drained",      5'b00001);

        for (int i = 0; i < 4 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_queue: got %0d pending want 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
